ocl_axil_arb2: RTL and testbench
================================

# ocl_axil_arb2

Two-port AXI4-Lite arbiter that shares one single-beat AXI-Lite register slave between two requesters: port 0, the host OCL path after its register slice, and port 1, an on-chip requester such as a debug/VIO sequencer. It sits between those masters and the CL register file in the `clk_main_a0` domain. It serializes traffic with exactly one transaction in flight, uses round-robin fairness between ports, and gives a write priority over a read within a port. All master-side signals are registered.

## Interface
- `ADDR_W`, 32: address width on all ports.
- `DATA_W`, 32: data width; strobe width is `DATA_W/8`.
- `clk_main_a0`  in  1  sole clock.
- `rst_main_sync`  in  1  synchronous reset, active-high.
- `sN_awvalid/sN_awaddr/sN_awready` (N=0,1)  in/in/out  1/ADDR_W/1  slave write address.
- `sN_wvalid/sN_wdata/sN_wstrb/sN_wready`  in/in/in/out  1/DATA_W/DATA_W/8/1  slave write data.
- `sN_bvalid/sN_bresp/sN_bready`  out/out/in  1/2/1  slave write response.
- `sN_arvalid/sN_araddr/sN_arready`  in/in/out  1/ADDR_W/1  slave read address.
- `sN_rvalid/sN_rdata/sN_rresp/sN_rready`  out/out/out/in  1/DATA_W/2/1  slave read data.
- `m_aw*, m_w*, m_b*, m_ar*, m_r*`  mirror  same widths  master port to the shared register slave.
- `busy`  out  1  high in any state other than IDLE.
- `grant_id`  out  1  port owning the current or most recent transaction.

## Operation
- States: IDLE, W_DATA, M_WR, M_B, S_B, M_AR, M_R, S_R.
- Port request is `awvalid | arvalid`. Within a port, a write wins when both are valid.
- Round-robin pointer `prio` resets to 0. In IDLE, if both ports request, `prio` wins; otherwise the sole requester wins.
- `prio` is set to the non-winning port when a transaction completes (S_B or S_R handshake). Each port is therefore guaranteed a grant within 2 transactions.
- IDLE grant, write: `sN_awready`=1 combinationally in the same cycle for the winner only. Capture awaddr, then go to W_DATA.
- W_DATA: `sN_wready`=1 for the granted port. On wvalid, capture wdata/wstrb and go to M_WR.
- M_WR: `m_awvalid` and `m_wvalid` are both asserted. Each deasserts independently when its ready is seen. Go to M_B once both handshakes have completed; they may complete in the same cycle or in different cycles.
- M_B: `m_bready`=1. On `m_bvalid`, capture bresp and go to S_B.
- S_B: `sN_bvalid`=1 with the captured bresp. On `sN_bready`, go to IDLE.
- IDLE grant, read: `sN_arready`=1 combinationally. Capture araddr, then go to M_AR.
- M_AR: `m_arvalid` held until `m_arready`, then go to M_R.
- M_R: `m_rready`=1. On `m_rvalid`, capture rdata/rresp and go to S_R.
- S_R: `sN_rvalid`=1. On `sN_rready`, go to IDLE.
- The non-granted port sees all readies and valids at 0 at all times. Its requests stall; nothing is dropped.
- Responses pass through unmodified; the arbiter never generates SLVERR or DECERR.
- Data and address outputs hold their last captured value while the matching valid is low.

## Timing
- Reset values: all valid/ready outputs 0; all addr/data/strb/resp outputs 0; `busy`=0; `grant_id`=0; `prio`=0; state IDLE.
- Reset asserted mid-transaction: at the next edge all valids drop and the state returns to IDLE. The in-flight transaction is abandoned with no response to the requester.
- Read latency with a zero-wait slave (responds in the cycle after arvalid): s-side AR handshake at cycle 0, `m_arvalid` at cycle 1, `m_rready` and `m_rvalid` at cycle 2, `sN_rvalid` at cycle 3.
- Write latency with wdata already valid and a zero-wait slave: AW handshake at cycle 0, W handshake at cycle 1, `m_awvalid`/`m_wvalid` at cycle 2, B at cycle 3, `sN_bvalid` at cycle 4.
- Back-to-back: the next grant can occur in the cycle after an S_B or S_R handshake. There is at most one grant per IDLE cycle.
- Master valids are held stable until their handshake completes, as AXI requires. They are never withdrawn, except by reset.

## Test plan
- Single read on port 0 from addr 0x500, with the slave returning 0x0DD0_BEEF and OKAY and never stalling -> `s0_rvalid` at cycle 3, `s0_rdata`=0x0DD0_BEEF, `s0_rresp`=0, `s1_*` outputs stay 0.
- Simultaneous port 0 write (addr 0x500, data 0x1234_5678) and port 1 read out of reset -> port 0 granted first. After its B handshake, port 1 is granted and `grant_id`=1.
- Port 0 holds awvalid and arvalid continuously while port 1 holds arvalid -> grants alternate 0,1,0,1; port 0 issues only writes until its awvalid drops.
- Write where `m_wready` arrives 3 cycles after `m_awready` -> `m_awvalid` drops after its handshake, `m_wvalid` is held, exactly one B is forwarded, `busy` is high throughout.
- Slave stalls `m_rvalid` for 10 cycles and port 0 stalls `s0_rready` for 5 cycles -> rdata is held stable and port 1 arvalid gets no arready until S_R completes.
- `rst_main_sync` pulsed while in M_B -> all outputs reach reset values the next cycle. A subsequent read completes normally, with `prio` at 0.

Source files
------------

// File: rtl/ocl_axil_arb2.sv
// rtl/ocl_axil_arb2.sv - two-port AXI4-Lite arbiter sharing one single-beat register slave
// One transaction in flight, round-robin between ports, write beats read within a port.
module ocl_axil_arb2 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_main_a0,
  input  logic                rst_main_sync,
  input  logic                s0_awvalid,
  input  logic [ADDR_W-1:0]   s0_awaddr,
  output logic                s0_awready,
  input  logic                s0_wvalid,
  input  logic [DATA_W-1:0]   s0_wdata,
  input  logic [DATA_W/8-1:0] s0_wstrb,
  output logic                s0_wready,
  output logic                s0_bvalid,
  output logic [1:0]          s0_bresp,
  input  logic                s0_bready,
  input  logic                s0_arvalid,
  input  logic [ADDR_W-1:0]   s0_araddr,
  output logic                s0_arready,
  output logic                s0_rvalid,
  output logic [DATA_W-1:0]   s0_rdata,
  output logic [1:0]          s0_rresp,
  input  logic                s0_rready,
  input  logic                s1_awvalid,
  input  logic [ADDR_W-1:0]   s1_awaddr,
  output logic                s1_awready,
  input  logic                s1_wvalid,
  input  logic [DATA_W-1:0]   s1_wdata,
  input  logic [DATA_W/8-1:0] s1_wstrb,
  output logic                s1_wready,
  output logic                s1_bvalid,
  output logic [1:0]          s1_bresp,
  input  logic                s1_bready,
  input  logic                s1_arvalid,
  input  logic [ADDR_W-1:0]   s1_araddr,
  output logic                s1_arready,
  output logic                s1_rvalid,
  output logic [DATA_W-1:0]   s1_rdata,
  output logic [1:0]          s1_rresp,
  input  logic                s1_rready,
  output logic                m_awvalid,
  output logic [ADDR_W-1:0]   m_awaddr,
  input  logic                m_awready,
  output logic                m_wvalid,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_wready,
  input  logic                m_bvalid,
  input  logic [1:0]          m_bresp,
  output logic                m_bready,
  output logic                m_arvalid,
  output logic [ADDR_W-1:0]   m_araddr,
  input  logic                m_arready,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  output logic                m_rready,
  output logic                busy,
  output logic                grant_id
);

  typedef enum logic [2:0] {IDLE, W_DATA, M_WR, M_B, S_B, M_AR, M_R, S_R} state_t;

  state_t                r_state, w_next;
  logic                  r_gnt, r_prio, r_aw_done, r_w_done;
  logic [ADDR_W-1:0]     r_awaddr, r_araddr;
  logic [DATA_W-1:0]     r_wdata, r_rdata0, r_rdata1;
  logic [DATA_W/8-1:0]   r_wstrb;
  logic [1:0]            r_bresp0, r_bresp1, r_rresp0, r_rresp1;

  logic w_req0, w_req1, w_win, w_win_wr, w_grant;
  logic w_s_wvalid, w_s_bready, w_s_rready, w_done;

  assign w_req0     = s0_awvalid | s0_arvalid;
  assign w_req1     = s1_awvalid | s1_arvalid;
  assign w_win      = (w_req0 & w_req1) ? r_prio : w_req1;
  assign w_win_wr   = w_win ? s1_awvalid : s0_awvalid;
  // Readies are suppressed while reset is held so nothing is accepted then dropped.
  assign w_grant    = (r_state == IDLE) & (w_req0 | w_req1) & ~rst_main_sync;
  assign w_s_wvalid = r_gnt ? s1_wvalid : s0_wvalid;
  assign w_s_bready = r_gnt ? s1_bready : s0_bready;
  assign w_s_rready = r_gnt ? s1_rready : s0_rready;
  assign w_done     = ((r_state == S_B) & w_s_bready) | ((r_state == S_R) & w_s_rready);

  always_comb begin
    w_next     = r_state;
    s0_awready = 1'b0; s0_wready = 1'b0; s0_bvalid = 1'b0; s0_arready = 1'b0; s0_rvalid = 1'b0;
    s1_awready = 1'b0; s1_wready = 1'b0; s1_bvalid = 1'b0; s1_arready = 1'b0; s1_rvalid = 1'b0;
    m_awvalid  = 1'b0; m_wvalid  = 1'b0; m_bready  = 1'b0; m_arvalid  = 1'b0; m_rready  = 1'b0;
    case (r_state)
      IDLE: if (w_grant) begin
        w_next     = w_win_wr ? W_DATA : M_AR;
        s0_awready = ~w_win & w_win_wr;
        s0_arready = ~w_win & ~w_win_wr;
        s1_awready = w_win & w_win_wr;
        s1_arready = w_win & ~w_win_wr;
      end
      W_DATA: begin
        s0_wready = ~r_gnt;
        s1_wready = r_gnt;
        if (w_s_wvalid) w_next = M_WR;
      end
      M_WR: begin
        m_awvalid = ~r_aw_done;
        m_wvalid  = ~r_w_done;
        if ((r_aw_done | m_awready) & (r_w_done | m_wready)) w_next = M_B;
      end
      M_B: begin
        m_bready = 1'b1;
        if (m_bvalid) w_next = S_B;
      end
      S_B: begin
        s0_bvalid = ~r_gnt;
        s1_bvalid = r_gnt;
        if (w_s_bready) w_next = IDLE;
      end
      M_AR: begin
        m_arvalid = 1'b1;
        if (m_arready) w_next = M_R;
      end
      M_R: begin
        m_rready = 1'b1;
        if (m_rvalid) w_next = S_R;
      end
      S_R: begin
        s0_rvalid = ~r_gnt;
        s1_rvalid = r_gnt;
        if (w_s_rready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_main_a0) begin
    if (rst_main_sync) r_state <= IDLE;
    else               r_state <= w_next;
  end

  always_ff @(posedge clk_main_a0) begin
    if (rst_main_sync) begin
      r_gnt     <= 1'b0;  r_prio    <= 1'b0;
      r_aw_done <= 1'b0;  r_w_done  <= 1'b0;
      r_awaddr  <= '0;    r_araddr  <= '0;
      r_wdata   <= '0;    r_wstrb   <= '0;
      r_rdata0  <= '0;    r_rdata1  <= '0;
      r_bresp0  <= '0;    r_bresp1  <= '0;
      r_rresp0  <= '0;    r_rresp1  <= '0;
    end else begin
      if (w_grant) begin
        r_gnt     <= w_win;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        if (w_win_wr) r_awaddr <= w_win ? s1_awaddr : s0_awaddr;
        else          r_araddr <= w_win ? s1_araddr : s0_araddr;
      end
      if ((r_state == W_DATA) && w_s_wvalid) begin
        r_wdata <= r_gnt ? s1_wdata : s0_wdata;
        r_wstrb <= r_gnt ? s1_wstrb : s0_wstrb;
      end
      if (m_awvalid && m_awready) r_aw_done <= 1'b1;
      if (m_wvalid && m_wready)   r_w_done  <= 1'b1;
      if (m_bready && m_bvalid) begin
        if (r_gnt) r_bresp1 <= m_bresp;
        else       r_bresp0 <= m_bresp;
      end
      if (m_rready && m_rvalid) begin
        if (r_gnt) begin r_rdata1 <= m_rdata; r_rresp1 <= m_rresp; end
        else       begin r_rdata0 <= m_rdata; r_rresp0 <= m_rresp; end
      end
      if (w_done) r_prio <= ~r_gnt;
    end
  end

  assign m_awaddr = r_awaddr;
  assign m_wdata  = r_wdata;
  assign m_wstrb  = r_wstrb;
  assign m_araddr = r_araddr;
  assign s0_bresp = r_bresp0;
  assign s1_bresp = r_bresp1;
  assign s0_rdata = r_rdata0;
  assign s0_rresp = r_rresp0;
  assign s1_rdata = r_rdata1;
  assign s1_rresp = r_rresp1;
  assign busy     = (r_state != IDLE);
  assign grant_id = r_gnt;

endmodule

// File: tb/tb_ocl_axil_arb2.sv
// tb/tb_ocl_axil_arb2.sv - directed self-checking bench for ocl_axil_arb2
// Small AXI-Lite slave model with programmable read latency, write-ready delay and B hold.
module tb_ocl_axil_arb2;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        s0_awvalid, s0_awready, s0_wvalid, s0_wready, s0_bvalid, s0_bready;
  logic        s0_arvalid, s0_arready, s0_rvalid, s0_rready;
  logic [31:0] s0_awaddr, s0_wdata, s0_araddr, s0_rdata;
  logic [3:0]  s0_wstrb;
  logic [1:0]  s0_bresp, s0_rresp;
  logic        s1_awvalid, s1_awready, s1_wvalid, s1_wready, s1_bvalid, s1_bready;
  logic        s1_arvalid, s1_arready, s1_rvalid, s1_rready;
  logic [31:0] s1_awaddr, s1_wdata, s1_araddr, s1_rdata;
  logic [3:0]  s1_wstrb;
  logic [1:0]  s1_bresp, s1_rresp;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;
  logic        busy, grant_id;

  ocl_axil_arb2 #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_main_a0(clk), .rst_main_sync(rst),
    .s0_awvalid(s0_awvalid), .s0_awaddr(s0_awaddr), .s0_awready(s0_awready),
    .s0_wvalid(s0_wvalid), .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wready(s0_wready),
    .s0_bvalid(s0_bvalid), .s0_bresp(s0_bresp), .s0_bready(s0_bready),
    .s0_arvalid(s0_arvalid), .s0_araddr(s0_araddr), .s0_arready(s0_arready),
    .s0_rvalid(s0_rvalid), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rready(s0_rready),
    .s1_awvalid(s1_awvalid), .s1_awaddr(s1_awaddr), .s1_awready(s1_awready),
    .s1_wvalid(s1_wvalid), .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wready(s1_wready),
    .s1_bvalid(s1_bvalid), .s1_bresp(s1_bresp), .s1_bready(s1_bready),
    .s1_arvalid(s1_arvalid), .s1_araddr(s1_araddr), .s1_arready(s1_arready),
    .s1_rvalid(s1_rvalid), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rready(s1_rready),
    .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rready(m_rready),
    .busy(busy), .grant_id(grant_id)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // slave model
  int          rd_delay = 0, w_delay = 0, rd_cnt = 0, w_cnt = 0;
  int          n_aw = 0, n_b = 0;
  logic        b_hold = 1'b0, r_bv = 1'b0, aw_got = 1'b0, w_got = 1'b0, rd_pend = 1'b0;
  logic [31:0] sl_rdata = '0, sl_wdata = '0;
  logic [1:0]  sl_rresp = '0, sl_bresp = '0;

  assign m_awready = 1'b1;
  assign m_wready  = m_wvalid && (w_cnt >= w_delay);
  assign m_bvalid  = r_bv && !b_hold;
  assign m_bresp   = sl_bresp;
  assign m_arready = 1'b1;
  assign m_rvalid  = rd_pend && (rd_cnt == 0);
  assign m_rdata   = sl_rdata;
  assign m_rresp   = sl_rresp;

  always @(posedge clk) begin
    if (rst) begin
      aw_got <= 1'b0; w_got <= 1'b0; r_bv <= 1'b0; rd_pend <= 1'b0; rd_cnt <= 0; w_cnt <= 0;
    end else begin
      if (m_awvalid && m_awready) n_aw <= n_aw + 1;
      if (m_wvalid && m_wready) sl_wdata <= m_wdata;
      if ((aw_got || (m_awvalid && m_awready)) && (w_got || (m_wvalid && m_wready))) begin
        r_bv <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        if (m_awvalid && m_awready) aw_got <= 1'b1;
        if (m_wvalid && m_wready)   w_got  <= 1'b1;
      end
      if (m_bvalid && m_bready) begin r_bv <= 1'b0; n_b <= n_b + 1; end
      w_cnt <= (m_wvalid && !m_wready) ? w_cnt + 1 : 0;
      if (m_arvalid && m_arready) begin rd_pend <= 1'b1; rd_cnt <= rd_delay; end
      else if (rd_pend && rd_cnt != 0) rd_cnt <= rd_cnt - 1;
      if (m_rvalid && m_rready) rd_pend <= 1'b0;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int c = 0;
    while (busy && c < 60) begin @(negedge clk); c++; end
    check(tag, busy, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  logic [1:0] exp_seq [5];
  logic [1:0] code;
  logic       saw_ar1;
  int         ng, c;
  int         nb0, naw0;

  initial begin
    rst = 1'b1;
    {s0_awvalid, s0_wvalid, s0_arvalid, s1_awvalid, s1_wvalid, s1_arvalid} = '0;
    {s0_awaddr, s0_wdata, s0_araddr, s1_awaddr, s1_wdata, s1_araddr} = '0;
    s0_wstrb = 4'h0; s1_wstrb = 4'h0;
    s0_bready = 1'b1; s0_rready = 1'b1; s1_bready = 1'b1; s1_rready = 1'b1;

    // reset values
    @(negedge clk);
    s0_awvalid = 1'b1;
    #1 check("rst_awready", s0_awready, 1'b0);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_grant", grant_id, 1'b0);
    check("rst_m_awvalid", m_awvalid, 1'b0);
    check("rst_m_arvalid", m_arvalid, 1'b0);
    check("rst_m_awaddr", m_awaddr, 32'h0);
    check("rst_s0_rdata", s0_rdata, 32'h0);
    s0_awvalid = 1'b0;
    rst = 1'b0;

    // single read on port 0, zero-wait slave
    @(negedge clk);
    s0_araddr = 32'h500; s0_arvalid = 1'b1; sl_rdata = 32'h0DD0_BEEF; sl_rresp = 2'b00;
    #1 check("t1_s0_arready", s0_arready, 1'b1);
    check("t1_s1_arready", s1_arready, 1'b0);
    @(negedge clk);
    s0_arvalid = 1'b0;
    check("t1_m_arvalid", m_arvalid, 1'b1);
    check("t1_m_araddr", m_araddr, 32'h500);
    @(negedge clk);
    check("t1_m_rready", m_rready, 1'b1);
    check("t1_m_rvalid", m_rvalid, 1'b1);
    @(negedge clk);
    check("t1_s0_rvalid", s0_rvalid, 1'b1);
    check("t1_s0_rdata", s0_rdata, 32'h0DD0_BEEF);
    check("t1_s0_rresp", s0_rresp, 2'b00);
    check("t1_s1_rvalid", s1_rvalid, 1'b0);
    check("t1_s1_rdata", s1_rdata, 32'h0);
    @(negedge clk);
    check("t1_idle", busy, 1'b0);

    // simultaneous port 0 write and port 1 read from reset
    do_reset();
    s0_awaddr = 32'h500; s0_awvalid = 1'b1; s0_wdata = 32'h1234_5678; s0_wstrb = 4'hF; s0_wvalid = 1'b1;
    s1_araddr = 32'h40; s1_arvalid = 1'b1; sl_bresp = 2'b10; sl_rdata = 32'hCAFE_0001;
    #1 check("t2_s0_awready", s0_awready, 1'b1);
    check("t2_s1_arready", s1_arready, 1'b0);
    @(negedge clk);
    s0_awvalid = 1'b0;
    check("t2_s0_wready", s0_wready, 1'b1);
    check("t2_grant0", grant_id, 1'b0);
    @(negedge clk);
    s0_wvalid = 1'b0;
    check("t2_m_awvalid", m_awvalid, 1'b1);
    check("t2_m_wvalid", m_wvalid, 1'b1);
    check("t2_m_awaddr", m_awaddr, 32'h500);
    check("t2_m_wdata", m_wdata, 32'h1234_5678);
    @(negedge clk);
    check("t2_m_bready", m_bready, 1'b1);
    @(negedge clk);
    check("t2_s0_bvalid", s0_bvalid, 1'b1);
    check("t2_s0_bresp", s0_bresp, 2'b10);
    check("t2_s1_stall", s1_arready, 1'b0);
    @(negedge clk);
    #1 check("t2_s1_arready", s1_arready, 1'b1);
    @(negedge clk);
    s1_arvalid = 1'b0;
    check("t2_grant1", grant_id, 1'b1);
    c = 0;
    while (!s1_rvalid && c < 20) begin @(negedge clk); c++; end
    check("t2_s1_rvalid", s1_rvalid, 1'b1);
    check("t2_s1_rdata", s1_rdata, 32'hCAFE_0001);
    check("t2_slave_wdata", sl_wdata, 32'h1234_5678);
    sl_bresp = 2'b00;
    @(negedge clk);

    // round-robin alternation with port 0 holding both awvalid and arvalid
    do_reset();
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10; exp_seq[4] = 2'b00;
    s0_awaddr = 32'h10; s0_wdata = 32'h11; s0_awvalid = 1'b1; s0_wvalid = 1'b1;
    s0_araddr = 32'h20; s0_arvalid = 1'b1; s1_araddr = 32'h30; s1_arvalid = 1'b1;
    ng = 0;
    for (int k = 0; k < 200 && ng < 5; k++) begin
      #1;
      if (s0_awready | s0_arready | s1_awready | s1_arready) begin
        code = {s1_awready | s1_arready, s0_awready | s1_awready};
        check($sformatf("t3_grant%0d", ng), code, exp_seq[ng]);
        ng++;
        if (ng == 4) s0_awvalid = 1'b0;
      end
      @(negedge clk);
    end
    check("t3_ngrants", ng, 5);
    s0_arvalid = 1'b0; s1_arvalid = 1'b0; s0_wvalid = 1'b0;
    wait_idle("t3_idle");

    // write with m_wready three cycles after m_awready
    w_delay = 3; nb0 = n_b; naw0 = n_aw;
    @(negedge clk);
    s0_awaddr = 32'h44; s0_awvalid = 1'b1; s0_wdata = 32'hA5A5_A5A5; s0_wstrb = 4'h3; s0_wvalid = 1'b1;
    #1 check("t4_s0_awready", s0_awready, 1'b1);
    @(negedge clk);
    s0_awvalid = 1'b0;
    @(negedge clk);
    s0_wvalid = 1'b0;
    check("t4_m_awvalid_c2", m_awvalid, 1'b1);
    check("t4_m_wvalid_c2", m_wvalid, 1'b1);
    for (int k = 3; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("t4_m_awvalid_c%0d", k), m_awvalid, 1'b0);
      check($sformatf("t4_m_wvalid_c%0d", k), m_wvalid, 1'b1);
      check($sformatf("t4_m_wready_c%0d", k), m_wready, k == 5);
      check($sformatf("t4_busy_c%0d", k), busy, 1'b1);
    end
    @(negedge clk);
    check("t4_m_wvalid_c6", m_wvalid, 1'b0);
    check("t4_m_bready_c6", m_bready, 1'b1);
    @(negedge clk);
    check("t4_s0_bvalid", s0_bvalid, 1'b1);
    check("t4_busy_c7", busy, 1'b1);
    @(negedge clk);
    check("t4_idle", busy, 1'b0);
    check("t4_one_b", n_b - nb0, 1);
    check("t4_one_aw", n_aw - naw0, 1);
    check("t4_wdata", sl_wdata, 32'hA5A5_A5A5);
    check("t4_wstrb", m_wstrb, 4'h3);
    w_delay = 0;

    // slave read stall of 10 cycles, requester stall of 5 cycles
    do_reset();
    rd_delay = 10; s0_rready = 1'b0; sl_rdata = 32'h600D_F00D; sl_rresp = 2'b01;
    s0_araddr = 32'h80; s0_arvalid = 1'b1; s1_araddr = 32'h84; s1_arvalid = 1'b1;
    #1 check("t5_s0_arready", s0_arready, 1'b1);
    check("t5_s1_arready", s1_arready, 1'b0);
    @(negedge clk);
    s0_arvalid = 1'b0;
    saw_ar1 = 1'b0; c = 0;
    while (!s0_rvalid && c < 30) begin saw_ar1 |= s1_arready; @(negedge clk); c++; end
    check("t5_s0_rvalid", s0_rvalid, 1'b1);
    check("t5_rlatency", c, 12);
    sl_rdata = 32'hFFFF_FFFF;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("t5_rdata_hold%0d", k), s0_rdata, 32'h600D_F00D);
      check($sformatf("t5_rvalid_hold%0d", k), s0_rvalid, 1'b1);
      saw_ar1 |= s1_arready;
      @(negedge clk);
    end
    s0_rready = 1'b1; rd_delay = 0;
    #1 check("t5_rresp", s0_rresp, 2'b01);
    saw_ar1 |= s1_arready;
    check("t5_no_s1_arready", saw_ar1, 1'b0);
    @(negedge clk);
    #1 check("t5_s1_arready", s1_arready, 1'b1);
    check("t5_s0_rvalid_off", s0_rvalid, 1'b0);
    @(negedge clk);
    s1_arvalid = 1'b0;
    wait_idle("t5_idle");

    // reset pulse in M_B; prio is 1 beforehand so the post-reset pick shows it returned to 0
    @(negedge clk);
    s0_araddr = 32'h4; s0_arvalid = 1'b1;
    @(negedge clk);
    s0_arvalid = 1'b0;
    wait_idle("t6_pre_idle");
    b_hold = 1'b1;
    s0_awaddr = 32'h500; s0_awvalid = 1'b1; s0_wdata = 32'h77; s0_wstrb = 4'hF; s0_wvalid = 1'b1;
    @(negedge clk);
    s0_awvalid = 1'b0;
    @(negedge clk);
    s0_wvalid = 1'b0;
    c = 0;
    while (!m_bready && c < 10) begin @(negedge clk); c++; end
    check("t6_in_mb", m_bready, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_busy", busy, 1'b0);
    check("t6_m_bready", m_bready, 1'b0);
    check("t6_m_awvalid", m_awvalid, 1'b0);
    check("t6_m_awaddr", m_awaddr, 32'h0);
    check("t6_m_wdata", m_wdata, 32'h0);
    check("t6_m_wstrb", m_wstrb, 4'h0);
    check("t6_s0_bvalid", s0_bvalid, 1'b0);
    check("t6_grant", grant_id, 1'b0);
    rst = 1'b0; b_hold = 1'b0;
    sl_rdata = 32'h1357_9BDF; sl_rresp = 2'b00;
    s0_araddr = 32'h8; s0_arvalid = 1'b1; s1_araddr = 32'hC; s1_arvalid = 1'b1;
    #1 check("t6_s0_arready", s0_arready, 1'b1);
    check("t6_s1_arready", s1_arready, 1'b0);
    @(negedge clk);
    s0_arvalid = 1'b0;
    c = 0;
    while (!s0_rvalid && c < 20) begin @(negedge clk); c++; end
    check("t6_s0_rvalid", s0_rvalid, 1'b1);
    check("t6_s0_rdata", s0_rdata, 32'h1357_9BDF);
    @(negedge clk);
    #1 check("t6_s1_next", s1_arready, 1'b1);
    @(negedge clk);
    s1_arvalid = 1'b0;
    wait_idle("t6_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
